// File: rtl/hs_rr_arbiter.sv
// hs_rr_arbiter: round-robin N:1 valid/ready arbiter with burst lock
// and a registered output stage tagged with the source index.
module hs_rr_arbiter #(
   parameter int WIDTH = 8,
   parameter int N     = 4,
   parameter int BURST = 4,
   parameter int SW    = $clog2(N)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               en,
   input  logic [N-1:0]       m_valid,
   input  logic [N*WIDTH-1:0] m_data,
   output logic [N-1:0]       m_ready,
   output logic               out_valid,
   output logic [WIDTH-1:0]   out_data,
   output logic [SW-1:0]      out_src,
   input  logic               out_ready
);

   typedef enum logic {UNLOCKED, LOCKED} state_t;

   localparam logic [7:0] BLAST = 8'(BURST);

   state_t           state;
   logic [SW-1:0]    ptr;
   logic [SW-1:0]    ptr_lock;
   logic [SW-1:0]    base;
   logic [SW-1:0]    gnt;
   logic [7:0]       beat_cnt;
   logic             gnt_vld;
   logic             free;
   logic             accept;
   logic             lock_live;
   logic [WIDTH-1:0] lane;

   assign free      = !out_valid || out_ready;
   assign lock_live = (state == LOCKED) && m_valid[ptr_lock];
   assign base      = (state == LOCKED) ? ptr_lock : ptr;

   // Descending scan: the smallest offset from base is written last and wins.
   always_comb begin
      int idx;
      gnt     = '0;
      gnt_vld = 1'b0;
      idx     = 0;
      if (lock_live) begin
         gnt     = ptr_lock;
         gnt_vld = 1'b1;
      end else begin
         for (int k = N; k >= 1; k--) begin
            idx = int'(base) + k;
            if (idx >= N) idx = idx - N;
            if (m_valid[idx]) begin
               gnt     = SW'(idx);
               gnt_vld = 1'b1;
            end
         end
      end
   end

   always_comb begin
      m_ready = '0;
      if (rst_n && free && en && gnt_vld) m_ready[gnt] = 1'b1;
   end

   assign accept = |(m_valid & m_ready);
   assign lane   = m_data[int'(gnt)*WIDTH +: WIDTH];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_src   <= '0;
         ptr       <= SW'(N-1);
         ptr_lock  <= '0;
         beat_cnt  <= '0;
         state     <= UNLOCKED;
      end else begin
         if (accept) begin
            out_valid <= 1'b1;
            out_data  <= lane;
            out_src   <= gnt;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end

         unique case (state)
            UNLOCKED: begin
               if (accept) begin
                  if (BURST == 1) begin
                     ptr <= gnt;
                  end else begin
                     ptr_lock <= gnt;
                     beat_cnt <= 8'd1;
                     state    <= LOCKED;
                  end
               end
            end
            LOCKED: begin
               if (free && en) begin
                  if (lock_live) begin
                     if (beat_cnt + 8'd1 == BLAST) begin
                        ptr      <= ptr_lock;
                        beat_cnt <= '0;
                        state    <= UNLOCKED;
                     end else begin
                        beat_cnt <= beat_cnt + 8'd1;
                     end
                  end else begin
                     // Lock dropped; a same-cycle winner starts a fresh burst.
                     ptr <= ptr_lock;
                     if (accept) begin
                        ptr_lock <= gnt;
                        beat_cnt <= 8'd1;
                     end else begin
                        beat_cnt <= '0;
                        state    <= UNLOCKED;
                     end
                  end
               end
            end
            default: state <= UNLOCKED;
         endcase
      end
   end

endmodule

// File: tb/tb_hs_rr_arbiter.sv
// tb_hs_rr_arbiter: scoreboard bench for hs_rr_arbiter, one DUT with
// BURST=4 and one with BURST=1 sharing the same stimulus.
module tb_hs_rr_arbiter;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        en = 1'b0;
   logic        out_ready = 1'b0;
   logic [3:0]  m_valid = '0;
   logic [31:0] m_data = '0;

   logic [3:0] m_ready4, m_ready1;
   logic       out_valid4, out_valid1;
   logic [7:0] out_data4, out_data1;
   logic [1:0] out_src4, out_src1;

   int vec = 0;
   int errs = 0;
   logic [9:0] q[$];
   logic [9:0] exp_b;

   hs_rr_arbiter #(.WIDTH(8), .N(4), .BURST(4)) u_dut4 (
      .clk(clk), .rst_n(rst_n), .en(en),
      .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready4),
      .out_valid(out_valid4), .out_data(out_data4), .out_src(out_src4),
      .out_ready(out_ready)
   );

   hs_rr_arbiter #(.WIDTH(8), .N(4), .BURST(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .en(en),
      .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready1),
      .out_valid(out_valid1), .out_data(out_data1), .out_src(out_src1),
      .out_ready(out_ready)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_lanes(input int k);
      for (int i = 0; i < 4; i++) m_data[i*8 +: 8] = {4'(i), 4'(k)};
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      m_valid = '0;
      en = 1'b1;
      out_ready = 1'b1;
      q.delete();
      step();
      step();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      m_valid = 4'hF;
      en = 1'b1;
      out_ready = 1'b1;
      rst_n = 1'b0;
      step();
      step();
      vec++;
      if ({out_valid4, out_src4, out_data4} !== 11'd0) begin
         errs++;
         $display("FAIL reset_out: got v=%b src=%0d data=%h want 0/0/00",
                  out_valid4, out_src4, out_data4);
      end
      vec++;
      if (m_ready4 !== 4'b0000 || m_ready1 !== 4'b0000) begin
         errs++;
         $display("FAIL reset_ready: got %b/%b want 0000", m_ready4, m_ready1);
      end
      vec++;
      if (out_valid1 !== 1'b0) begin
         errs++;
         $display("FAIL reset_out1: got v=%b want 0", out_valid1);
      end
      m_valid = '0;
      rst_n = 1'b1;
   endtask

   task automatic test_single();
      do_reset();
      set_lanes(0);
      m_data[23:16] = 8'hA5;
      m_valid = 4'b0100;
      @(negedge clk);
      vec++;
      if (m_ready4 !== 4'b0100) begin
         errs++;
         $display("FAIL single_ready: got %b want 0100", m_ready4);
      end
      q.push_back({2'd2, 8'hA5});
      step();
      m_valid = '0;
      @(negedge clk);
      exp_b = q.pop_front();
      vec++;
      if ({out_valid4, out_src4, out_data4} !== {1'b1, exp_b}) begin
         errs++;
         $display("FAIL single_out: got v=%b src=%0d data=%h want v=1 src=%0d data=%h",
                  out_valid4, out_src4, out_data4, exp_b[9:8], exp_b[7:0]);
      end
      vec++;
      if (m_ready4 !== 4'b0000) begin
         errs++;
         $display("FAIL single_idle_ready: got %b want 0000", m_ready4);
      end
      step();
      @(negedge clk);
      vec++;
      if (out_valid4 !== 1'b0) begin
         errs++;
         $display("FAIL single_drain: got v=%b want 0", out_valid4);
      end
      step();
   endtask

   task automatic test_rr_burst1();
      int s;
      do_reset();
      m_valid = 4'hF;
      for (int k = 0; k <= 6; k++) begin
         set_lanes(k);
         if (k == 6) m_valid = '0;
         @(negedge clk);
         if (q.size() > 0) begin
            exp_b = q.pop_front();
            vec++;
            if ({out_valid1, out_src1, out_data1} !== {1'b1, exp_b}) begin
               errs++;
               $display("FAIL rr1_out[%0d]: got v=%b src=%0d data=%h want src=%0d data=%h",
                        k, out_valid1, out_src1, out_data1, exp_b[9:8], exp_b[7:0]);
            end
         end
         if (k < 6) begin
            s = k % 4;
            vec++;
            if (m_ready1 !== 4'(1 << s)) begin
               errs++;
               $display("FAIL rr1_ready[%0d]: got %b want %b", k, m_ready1, 4'(1 << s));
            end
            q.push_back({2'(s), 4'(s), 4'(k)});
         end
         step();
      end
   endtask

   task automatic test_burst_rotation();
      int s;
      do_reset();
      m_valid = 4'hF;
      for (int k = 0; k <= 12; k++) begin
         set_lanes(k);
         if (k == 12) m_valid = '0;
         @(negedge clk);
         if (q.size() > 0) begin
            exp_b = q.pop_front();
            vec++;
            if ({out_valid4, out_src4, out_data4} !== {1'b1, exp_b}) begin
               errs++;
               $display("FAIL burst_out[%0d]: got v=%b src=%0d data=%h want src=%0d data=%h",
                        k, out_valid4, out_src4, out_data4, exp_b[9:8], exp_b[7:0]);
            end
         end
         if (k < 12) begin
            s = (k / 4) % 4;
            vec++;
            if (m_ready4 !== 4'(1 << s)) begin
               errs++;
               $display("FAIL burst_ready[%0d]: got %b want %b", k, m_ready4, 4'(1 << s));
            end
            q.push_back({2'(s), 4'(s), 4'(k)});
         end
         step();
      end
   endtask

   task automatic test_lock_abandon();
      logic [3:0] vtab [8] = '{4'hF, 4'hF, 4'hE, 4'hE, 4'hE, 4'hE, 4'hE, 4'h0};
      int stab [7] = '{0, 0, 1, 1, 1, 1, 2};
      do_reset();
      for (int k = 0; k <= 7; k++) begin
         m_valid = vtab[k];
         set_lanes(k);
         @(negedge clk);
         if (q.size() > 0) begin
            exp_b = q.pop_front();
            vec++;
            if ({out_valid4, out_src4, out_data4} !== {1'b1, exp_b}) begin
               errs++;
               $display("FAIL abandon_out[%0d]: got v=%b src=%0d data=%h want src=%0d data=%h",
                        k, out_valid4, out_src4, out_data4, exp_b[9:8], exp_b[7:0]);
            end
         end
         if (k < 7) begin
            vec++;
            if (m_ready4 !== 4'(1 << stab[k])) begin
               errs++;
               $display("FAIL abandon_ready[%0d]: got %b want %b",
                        k, m_ready4, 4'(1 << stab[k]));
            end
            q.push_back({2'(stab[k]), 4'(stab[k]), 4'(k)});
         end
         step();
      end
   endtask

   task automatic test_stall();
      do_reset();
      set_lanes(0);
      m_data[7:0] = 8'h5A;
      m_valid = 4'b0001;
      @(negedge clk);
      vec++;
      if (m_ready4 !== 4'b0001) begin
         errs++;
         $display("FAIL stall_first_ready: got %b want 0001", m_ready4);
      end
      q.push_back({2'd0, 8'h5A});
      step();
      out_ready = 1'b0;
      m_data[7:0] = 8'h11;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         vec++;
         if ({out_valid4, out_src4, out_data4} !== {1'b1, q[0]} || m_ready4 !== 4'b0000) begin
            errs++;
            $display("FAIL stall_hold[%0d]: got v=%b src=%0d data=%h rdy=%b want v=1 src=%0d data=%h rdy=0000",
                     c, out_valid4, out_src4, out_data4, m_ready4, q[0][9:8], q[0][7:0]);
         end
         step();
         m_data[7:0] = 8'(8'h20 + c);
      end
      out_ready = 1'b1;
      m_data[7:0] = 8'h77;
      @(negedge clk);
      exp_b = q.pop_front();
      vec++;
      if ({out_valid4, out_src4, out_data4} !== {1'b1, exp_b}) begin
         errs++;
         $display("FAIL stall_release_out: got v=%b src=%0d data=%h want src=%0d data=%h",
                  out_valid4, out_src4, out_data4, exp_b[9:8], exp_b[7:0]);
      end
      vec++;
      if (m_ready4 !== 4'b0001) begin
         errs++;
         $display("FAIL stall_release_ready: got %b want 0001", m_ready4);
      end
      q.push_back({2'd0, 8'h77});
      step();
      m_valid = '0;
      @(negedge clk);
      exp_b = q.pop_front();
      vec++;
      if ({out_valid4, out_src4, out_data4} !== {1'b1, exp_b}) begin
         errs++;
         $display("FAIL stall_next_out: got v=%b src=%0d data=%h want src=%0d data=%h",
                  out_valid4, out_src4, out_data4, exp_b[9:8], exp_b[7:0]);
      end
      step();
   endtask

   task automatic test_enable();
      int s;
      do_reset();
      m_valid = 4'hF;
      for (int k = 0; k <= 8; k++) begin
         set_lanes(k);
         en = (k < 2 || k > 3) ? 1'b1 : 1'b0;
         if (k == 8) m_valid = '0;
         @(negedge clk);
         if (q.size() > 0) begin
            exp_b = q.pop_front();
            vec++;
            if ({out_valid4, out_src4, out_data4} !== {1'b1, exp_b}) begin
               errs++;
               $display("FAIL en_out[%0d]: got v=%b src=%0d data=%h want src=%0d data=%h",
                        k, out_valid4, out_src4, out_data4, exp_b[9:8], exp_b[7:0]);
            end
         end else begin
            vec++;
            if (out_valid4 !== 1'b0) begin
               errs++;
               $display("FAIL en_idle[%0d]: got v=%b want 0", k, out_valid4);
            end
         end
         if (k == 2 || k == 3) begin
            vec++;
            if (m_ready4 !== 4'b0000) begin
               errs++;
               $display("FAIL en_off_ready[%0d]: got %b want 0000", k, m_ready4);
            end
         end else if (k < 8) begin
            s = (k < 6) ? 0 : 1;
            vec++;
            if (m_ready4 !== 4'(1 << s)) begin
               errs++;
               $display("FAIL en_ready[%0d]: got %b want %b", k, m_ready4, 4'(1 << s));
            end
            q.push_back({2'(s), 4'(s), 4'(k)});
         end
         step();
      end
      en = 1'b1;
   endtask

   task automatic test_async_reset();
      int s;
      do_reset();
      m_valid = 4'hF;
      for (int k = 0; k < 2; k++) begin
         set_lanes(k);
         @(negedge clk);
         vec++;
         if (m_ready4 !== 4'b0001) begin
            errs++;
            $display("FAIL arst_pre_ready[%0d]: got %b want 0001", k, m_ready4);
         end
         step();
      end
      vec++;
      if (out_valid4 !== 1'b1) begin
         errs++;
         $display("FAIL arst_pre_valid: got v=%b want 1", out_valid4);
      end
      #2;
      rst_n = 1'b0;
      #1;
      vec++;
      if (out_valid4 !== 1'b0 || m_ready4 !== 4'b0000) begin
         errs++;
         $display("FAIL arst_immediate: got v=%b rdy=%b want v=0 rdy=0000",
                  out_valid4, m_ready4);
      end
      m_valid = '0;
      q.delete();
      @(negedge clk);
      #2;
      rst_n = 1'b1;
      step();
      m_valid = 4'hF;
      for (int k = 0; k <= 5; k++) begin
         set_lanes(k);
         if (k == 5) m_valid = '0;
         @(negedge clk);
         if (q.size() > 0) begin
            exp_b = q.pop_front();
            vec++;
            if ({out_valid4, out_src4, out_data4} !== {1'b1, exp_b}) begin
               errs++;
               $display("FAIL arst_out[%0d]: got v=%b src=%0d data=%h want src=%0d data=%h",
                        k, out_valid4, out_src4, out_data4, exp_b[9:8], exp_b[7:0]);
            end
         end
         if (k < 5) begin
            s = (k < 4) ? 0 : 1;
            vec++;
            if (m_ready4 !== 4'(1 << s)) begin
               errs++;
               $display("FAIL arst_ready[%0d]: got %b want %b", k, m_ready4, 4'(1 << s));
            end
            q.push_back({2'(s), 4'(s), 4'(k)});
         end
         step();
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_rr_burst1();
      test_burst_rotation();
      test_lock_abandon();
      test_stall();
      test_enable();
      test_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
      $finish;
   end

endmodule

// File: doc/hs_rr_arbiter.md
Name: hs_rr_arbiter

Overview:
Round-robin arbiter that shares one downstream valid/ready consumer (the slave handshake stage) among N upstream requesters. It selects one requester per beat, forwards its data through a registered output stage, and tags each beat with its source index. A burst lock lets a winner keep the grant for up to BURST consecutive beats, which limits interleaving while still guaranteeing fairness.

Parameters:
- WIDTH, 8, data width of each requester and of the output.
- N, 4, number of requesters (2..16).
- BURST, 4, maximum consecutive accepted beats per grant (1..255).
- SW, $clog2(N), width of the source index (derived; must not be overridden).

Ports:
- clk  in  1  system clock, all logic rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  arbitration enable. 0 = no new beats accepted; the output stage still drains.
- m_valid  in  N  per-requester valid.
- m_data  in  N*WIDTH  requester i data in bits [i*WIDTH +: WIDTH].
- m_ready  out  N  per-requester ready, one-hot or zero.
- out_valid  out  1  registered output valid.
- out_data  out  WIDTH  registered output data.
- out_src  out  SW  index of the requester that produced the current beat.
- out_ready  in  1  downstream ready.

Behaviour:
- Reset values:
  - out_valid=0, out_data=0, out_src=0.
  - Priority pointer ptr=N-1, so requester 0 has highest priority first.
  - beat_cnt=0, lock=0.
  - m_ready forced to all-zero while rst_n is low.
- Slot free: `free = !out_valid || out_ready`.
- Grant (combinational):
  - If lock=1 and m_valid[ptr_lock] is high, the grant is ptr_lock.
  - Otherwise the grant is the first i with m_valid[i] high, searching (ptr+1) mod N upward with wrap.
  - There is no grant when m_valid is all-zero.
- m_ready[g] = free && en && grant valid. All other bits are 0. m_ready may depend on m_valid; m_valid must not depend on m_ready.
- Accept occurs when m_valid[g] && m_ready[g]. On the next edge:
  - out_data <= m_data[g], out_src <= g, out_valid <= 1.
  - Latency is 1 cycle from accept to out_valid.
  - Throughput is 1 beat/cycle while out_ready=1.
- Output stage:
  - If out_valid && out_ready with no accept in the same cycle, out_valid <= 0.
  - If out_valid && !out_ready, out_data and out_src hold stable and m_ready is all-zero.
- Burst lock FSM, states UNLOCKED and LOCKED:
  - UNLOCKED, on accept from g:
    - If BURST==1: ptr <= g, remain UNLOCKED.
    - Else: ptr_lock <= g, beat_cnt <= 1, go to LOCKED.
  - LOCKED, on accept from ptr_lock: beat_cnt increments. When beat_cnt+1 == BURST: ptr <= ptr_lock, beat_cnt <= 0, go to UNLOCKED.
  - LOCKED, m_valid[ptr_lock] low in a cycle where free && en:
    - Lock is abandoned in that same cycle: ptr <= ptr_lock, go to UNLOCKED.
    - Normal round-robin grant applies combinationally in that cycle, so another requester can be accepted without a bubble.
  - LOCKED while !free or !en: hold state and beat_cnt.
- Fairness: under continuous requests from all N requesters, every requester receives at least one beat within N*BURST accepted beats.
- en=0:
  - No accepts; the FSM, ptr and beat_cnt hold.
  - The output stage still presents and drains its held beat.
- Asynchronous reset mid-burst:
  - All state returns to reset values immediately.
  - Any beat held in the output stage is discarded.
- Data source: out_data always comes from the granted lane at the accept cycle. Other lanes' data is ignored.

Test Plan:
1. Only requester 2 valid, data 0xA5, out_ready=1, en=1 -> m_ready=4'b0100 in the same cycle; next cycle out_valid=1, out_data=0xA5, out_src=2.
2. All 4 requesters valid continuously, BURST=1, out_ready=1 -> out_src sequence 0,1,2,3,0,1, one beat per cycle.
3. All 4 requesters valid continuously, BURST=4 -> out_src sequence 0,0,0,0,1,1,1,1,2,...; requester 0 drops valid after 2 beats -> next beats come from requester 1 with no idle cycle.
4. out_ready held 0 for 5 cycles with a beat in the output stage -> out_data and out_src stable, m_ready=0 throughout; out_ready=1 -> held beat drains and a new accept occurs in the same cycle.
5. en=0 with all requesters valid -> m_ready=0 and out_valid falls after its pending beat drains; en=1 -> arbitration resumes from the saved ptr and beat_cnt.
6. rst_n pulsed low mid-burst (beat_cnt=2, out_valid=1) -> out_valid=0 and m_ready=0 immediately; after release, the first grant goes to requester 0.
